// File: rtl/cyq_seq_gen.sv
// Serial test-pattern transmitter: shifts a latched pattern out on X, MSB of the window first, Reps times.
// Optional even-parity bit after each repetition when CYQ_GEN_PARITY_EN is defined.
module cyq_seq_gen #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned REP_W = 4,
    localparam int unsigned LEN_W = $clog2(PAT_W) + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [PAT_W-1:0] Pattern,
    input  logic [LEN_W-1:0] Len,
    input  logic [REP_W-1:0] Reps,
    input  logic             Abort,
    output logic             X,
    output logic             X_vld,
    output logic             Busy,
    output logic             Done
);
    localparam int unsigned IDX_W = $clog2(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
`ifdef CYQ_GEN_PARITY_EN
        S_PAR  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t            r_state, w_state_n;
    logic [PAT_W-1:0]  r_pat, w_pat_n;
    logic [IDX_W-1:0]  r_last, w_last_n;
    logic [IDX_W-1:0]  r_idx, w_idx_n;
    logic [REP_W-1:0]  r_rep, w_rep_n;
    logic              r_x, r_vld, r_busy, r_done;
    logic              w_x_n, w_vld_n, w_busy_n, w_done_n;
    logic [LEN_W-1:0]  w_len_eff;
    logic [REP_W-1:0]  w_reps_eff;
    logic [PAT_W-1:0]  w_mask;
    logic              w_wrap;

    // Clamp request fields and build a mask so bits above the window never leak into parity
    always_comb begin
        w_len_eff  = (Len == '0 || Len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : Len;
        w_reps_eff = (Reps == '0) ? REP_W'(1) : Reps;
        w_mask     = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < w_len_eff);
        end
    end

    // Next-state and next-output logic; r_idx is the index of the bit currently on X
    always_comb begin
        w_state_n = r_state;
        w_pat_n   = r_pat;
        w_last_n  = r_last;
        w_idx_n   = r_idx;
        w_rep_n   = r_rep;
        w_x_n     = 1'b0;
        w_vld_n   = 1'b0;
        w_busy_n  = 1'b0;
        w_done_n  = 1'b0;
        w_wrap    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (Start && !Abort) begin
                    w_pat_n   = Pattern & w_mask;
                    w_last_n  = IDX_W'(w_len_eff - LEN_W'(1));
                    w_idx_n   = w_last_n;
                    w_rep_n   = w_reps_eff;
                    w_x_n     = Pattern[w_last_n];
                    w_vld_n   = 1'b1;
                    w_busy_n  = 1'b1;
                    w_state_n = S_SEND;
                end
            end
            S_SEND: begin
                if (Abort) begin
                    w_state_n = S_IDLE;
                end else if (r_idx != '0) begin
                    w_idx_n  = r_idx - IDX_W'(1);
                    w_x_n    = r_pat[w_idx_n];
                    w_vld_n  = 1'b1;
                    w_busy_n = 1'b1;
                end else begin
`ifdef CYQ_GEN_PARITY_EN
                    w_state_n = S_PAR;
                    w_x_n     = ^r_pat;
                    w_vld_n   = 1'b1;
                    w_busy_n  = 1'b1;
`else
                    w_wrap    = 1'b1;
`endif
                end
            end
`ifdef CYQ_GEN_PARITY_EN
            S_PAR: begin
                if (Abort) begin
                    w_state_n = S_IDLE;
                end else begin
                    w_wrap = 1'b1;
                end
            end
`endif
            S_DONE: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // End of a repetition: finish, or reload the window with no gap cycle
        if (w_wrap) begin
            w_busy_n = 1'b1;
            if (r_rep <= REP_W'(1)) begin
                w_state_n = S_DONE;
                w_done_n  = 1'b1;
            end else begin
                w_state_n = S_SEND;
                w_rep_n   = r_rep - REP_W'(1);
                w_idx_n   = r_last;
                w_x_n     = r_pat[r_last];
                w_vld_n   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_last  <= '0;
            r_idx   <= '0;
            r_rep   <= '0;
            r_x     <= 1'b0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pat   <= w_pat_n;
            r_last  <= w_last_n;
            r_idx   <= w_idx_n;
            r_rep   <= w_rep_n;
            r_x     <= w_x_n;
            r_vld   <= w_vld_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
        end
    end

    assign X     = r_x;
    assign X_vld = r_vld;
    assign Busy  = r_busy;
    assign Done  = r_done;

endmodule
